// File: rtl/clause_bank_loader.sv
// Packs a serial coefficient stream into one (2^V+1)-coefficient word per clause, writes it to the clause bank and builds the reduce-enable mask.
// Latency: ready 1 cycle after in_start; K accept cycles + 1 WRITE cycle per clause; out_done the cycle after the last WRITE.
// Backpressure: ready only in COLLECT, waits indefinitely on low valid; optional CLAUSE_LOADER_ZERO_CLAUSE_MASK_EN masks all-zero clauses.

module clause_bank_loader #(
  parameter int MAXIMUM_BIT_WIDTH_OF_COEFFICIENT    = 8,
  parameter int MAXIMUM_BIT_WIDTH_OF_VARIABLE_INDEX = 2,
  parameter int MAX_BIT_WIDTH_OF_CLAUSES_INDEX      = 3
) (
  input  logic                                              in_clk,
  input  logic                                              in_reset,
  input  logic                                              in_start,
  input  logic [MAX_BIT_WIDTH_OF_CLAUSES_INDEX:0]           in_num_clauses,
  input  logic                                              in_coefficient_valid,
  input  logic [MAXIMUM_BIT_WIDTH_OF_COEFFICIENT-1:0]       in_coefficient,
  output logic                                              out_coefficient_ready,
  output logic [((1 << MAXIMUM_BIT_WIDTH_OF_VARIABLE_INDEX) + 1)
                * MAXIMUM_BIT_WIDTH_OF_COEFFICIENT - 1:0]   out_clause_coefficients,
  output logic [MAX_BIT_WIDTH_OF_CLAUSES_INDEX-1:0]         out_clause_index,
  output logic                                              out_clause_write,
  output logic [(1 << MAX_BIT_WIDTH_OF_CLAUSES_INDEX)-1:0]  out_reduce_enable,
  output logic                                              out_busy,
  output logic                                              out_done
);

  localparam int W    = MAXIMUM_BIT_WIDTH_OF_COEFFICIENT;
  localparam int NVAR = 1 << MAXIMUM_BIT_WIDTH_OF_VARIABLE_INDEX;
  localparam int K    = NVAR + 1;
  localparam int KW   = K * W;
  localparam int C    = MAX_BIT_WIDTH_OF_CLAUSES_INDEX;
  localparam int BW   = $clog2(K);

  localparam logic [BW-1:0] LAST_BEAT  = BW'(K - 1);
  localparam logic [C:0]    TARGET_MAX = {1'b1, {C{1'b0}}};

  typedef enum logic [1:0] {
    IDLE,
    COLLECT,
    WRITE,
    DONE
  } state_t;

  state_t          state;
  logic [C:0]      target;
  logic [BW-1:0]   beat;
  logic [KW-1:0]   word_acc;
  logic [KW-1:0]   word_next;
  logic            set_enable;
  logic            last_clause;

  // Word as it will look once the beat currently on the bus lands in its slice.
  always_comb begin
    word_next = word_acc;
    word_next[beat*W +: W] = in_coefficient;
  end

`ifdef CLAUSE_LOADER_ZERO_CLAUSE_MASK_EN
  assign set_enable = |out_clause_coefficients[NVAR*W-1:0];
`else
  assign set_enable = 1'b1;
`endif

  assign last_clause = ({1'b0, out_clause_index} + {{C{1'b0}}, 1'b1}) == target;

  always_ff @(posedge in_clk) begin
    if (in_reset) begin
      state                   <= IDLE;
      target                  <= '0;
      beat                    <= '0;
      word_acc                <= '0;
      out_coefficient_ready   <= 1'b0;
      out_clause_coefficients <= '0;
      out_clause_index        <= '0;
      out_clause_write        <= 1'b0;
      out_reduce_enable       <= '0;
      out_busy                <= 1'b0;
      out_done                <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_start) begin
            target            <= (in_num_clauses > TARGET_MAX) ? TARGET_MAX : in_num_clauses;
            out_reduce_enable <= '0;
            out_clause_index  <= '0;
            beat              <= '0;
            word_acc          <= '0;
            if (in_num_clauses == '0) begin
              state    <= DONE;
              out_done <= 1'b1;
            end else begin
              state                 <= COLLECT;
              out_coefficient_ready <= 1'b1;
              out_busy              <= 1'b1;
            end
          end
        end

        COLLECT: begin
          if (in_coefficient_valid) begin
            word_acc <= word_next;
            if (beat == LAST_BEAT) begin
              out_clause_coefficients <= word_next;
              out_coefficient_ready   <= 1'b0;
              out_clause_write        <= 1'b1;
              state                   <= WRITE;
            end else begin
              beat <= beat + {{(BW-1){1'b0}}, 1'b1};
            end
          end
        end

        WRITE: begin
          out_clause_write <= 1'b0;
          if (set_enable) begin
            out_reduce_enable[out_clause_index] <= 1'b1;
          end
          if (last_clause) begin
            state    <= DONE;
            out_busy <= 1'b0;
            out_done <= 1'b1;
          end else begin
            // Start the next clause from a clean word so no slice carries over.
            out_clause_index      <= out_clause_index + {{(C-1){1'b0}}, 1'b1};
            beat                  <= '0;
            word_acc              <= '0;
            out_coefficient_ready <= 1'b1;
            state                 <= COLLECT;
          end
        end

        DONE: begin
          out_done <= 1'b0;
          state    <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_clause_bank_loader.sv
// Directed-random bench for clause_bank_loader: a source model streams clause coefficients and a reference packs words and masks.

module tb_clause_bank_loader;

  localparam int W   = 8;
  localparam int V   = 2;
  localparam int C   = 3;
  localparam int NV  = 1 << V;
  localparam int K   = NV + 1;
  localparam int NCL = 1 << C;

  logic              in_clk = 1'b0;
  logic              in_reset;
  logic              in_start;
  logic [C:0]        in_num_clauses;
  logic              in_coefficient_valid;
  logic [W-1:0]      in_coefficient;
  logic              out_coefficient_ready;
  logic [K*W-1:0]    out_clause_coefficients;
  logic [C-1:0]      out_clause_index;
  logic              out_clause_write;
  logic [NCL-1:0]    out_reduce_enable;
  logic              out_busy;
  logic              out_done;

  always #5 in_clk = ~in_clk;

  clause_bank_loader #(
    .MAXIMUM_BIT_WIDTH_OF_COEFFICIENT   (W),
    .MAXIMUM_BIT_WIDTH_OF_VARIABLE_INDEX(V),
    .MAX_BIT_WIDTH_OF_CLAUSES_INDEX     (C)
  ) dut (
    .in_clk                 (in_clk),
    .in_reset               (in_reset),
    .in_start               (in_start),
    .in_num_clauses         (in_num_clauses),
    .in_coefficient_valid   (in_coefficient_valid),
    .in_coefficient         (in_coefficient),
    .out_coefficient_ready  (out_coefficient_ready),
    .out_clause_coefficients(out_clause_coefficients),
    .out_clause_index       (out_clause_index),
    .out_clause_write       (out_clause_write),
    .out_reduce_enable      (out_reduce_enable),
    .out_busy               (out_busy),
    .out_done               (out_done)
  );

  int checks = 0;
  int errors = 0;

  logic [W-1:0]   coef [NCL][K];
  logic [K*W-1:0] ew   [NCL];
  logic [K*W-1:0] first_word;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: random clause set, packed by arithmetic shifts (bias at the top).
  task automatic gen_data(input bit fixed0, input bit zero1);
    for (int i = 0; i < NCL; i++)
      for (int k = 0; k < K; k++)
        coef[i][k] = W'($urandom);
    if (fixed0) begin
      coef[0][0] = 8'd1;
      coef[0][1] = 8'd2;
      coef[0][2] = 8'd3;
      coef[0][3] = 8'd4;
      coef[0][4] = -8'sd5;
    end
    if (zero1) begin
      for (int k = 0; k < NV; k++) coef[1][k] = '0;
      coef[1][NV] = 8'd7;
    end
    for (int i = 0; i < NCL; i++) begin
      ew[i] = '0;
      for (int k = 0; k < K; k++)
        ew[i] = ew[i] | ({{((K-1)*W){1'b0}}, coef[i][k]} << (k * W));
    end
  endtask

  function automatic logic [NCL-1:0] exp_mask(input int n);
    logic [NCL-1:0] m;
    bit             all_zero;
    m = '0;
    for (int i = 0; i < n; i++) begin
      all_zero = 1'b1;
      for (int k = 0; k < NV; k++)
        if (coef[i][k] != '0) all_zero = 1'b0;
`ifdef CLAUSE_LOADER_ZERO_CLAUSE_MASK_EN
      if (!all_zero) m[i] = 1'b1;
`else
      m[i] = 1'b1;
`endif
    end
    return m;
  endfunction

  task automatic run_load(input int n_req, input bit stall, input int abort_after, input string name);
    int n;
    int total;
    int ptr;
    bit pend;
    int wcount;
    int ready_cycles;
    int done_cyc;
    int strobes_after;
    n             = (n_req > NCL) ? NCL : n_req;
    total         = n * K;
    ptr           = 0;
    pend          = 1'b0;
    wcount        = 0;
    ready_cycles  = 0;
    done_cyc      = -1;
    strobes_after = 0;

    @(negedge in_clk);
    in_start       = 1'b1;
    in_num_clauses = (C+1)'(n_req);
    @(negedge in_clk);
    in_start = 1'b0;

    for (int cyc = 0; cyc < 800; cyc++) begin
      if (pend) ptr++;
      if (cyc == 0 && n > 0) begin
        check({name, "_first_ready"}, out_coefficient_ready, 1);
        check({name, "_busy"}, out_busy, 1);
      end
      if (out_coefficient_ready) ready_cycles++;
      if (out_clause_write) begin
        check({name, "_index"}, out_clause_index, wcount);
        check({name, "_word"}, out_clause_coefficients, ew[wcount]);
        check({name, "_no_ready_in_write"}, out_coefficient_ready, 0);
        if (!stall) check({name, "_write_cycle"}, cyc, 5 + 6 * wcount);
        if (wcount == 0) first_word = out_clause_coefficients;
        wcount++;
        if (abort_after != 0 && wcount == abort_after) begin
          in_reset             = 1'b1;
          in_coefficient_valid = 1'b0;
          @(negedge in_clk);
          check({name, "_rst_ready"}, out_coefficient_ready, 0);
          check({name, "_rst_write"}, out_clause_write, 0);
          check({name, "_rst_busy"}, out_busy, 0);
          check({name, "_rst_done"}, out_done, 0);
          check({name, "_rst_mask"}, out_reduce_enable, 0);
          check({name, "_rst_word"}, out_clause_coefficients, 0);
          check({name, "_rst_index"}, out_clause_index, 0);
          in_reset = 1'b0;
          for (int j = 0; j < 20; j++) begin
            @(negedge in_clk);
            if (out_clause_write) strobes_after++;
          end
          check({name, "_no_strobe_after_rst"}, strobes_after, 0);
          return;
        end
      end
      if (out_done) begin
        done_cyc = cyc;
        break;
      end
      in_start             = (cyc == 3);
      in_coefficient_valid = (ptr < total) && (!stall || (cyc % 2 == 0));
      in_coefficient       = (ptr < total) ? coef[ptr / K][ptr % K] : '0;
      pend                 = in_coefficient_valid && out_coefficient_ready;
      @(negedge in_clk);
    end
    in_start             = 1'b0;
    in_coefficient_valid = 1'b0;

    check({name, "_done_seen"}, (done_cyc >= 0), 1);
    if (!stall) begin
      check({name, "_done_cycle"}, done_cyc, 6 * n);
      check({name, "_ready_cycles"}, ready_cycles, n * K);
    end
    check({name, "_writes"}, wcount, n);
    check({name, "_beats"}, ptr, total);
    check({name, "_mask"}, out_reduce_enable, exp_mask(n));
    check({name, "_busy_at_done"}, out_busy, 0);
    @(negedge in_clk);
    check({name, "_done_pulse"}, out_done, 0);
    check({name, "_mask_hold"}, out_reduce_enable, exp_mask(n));
  endtask

  initial begin
    in_reset             = 1'b1;
    in_start             = 1'b0;
    in_num_clauses       = '0;
    in_coefficient_valid = 1'b0;
    in_coefficient       = '0;
    first_word           = '0;
    repeat (3) @(negedge in_clk);
    check("reset_ready", out_coefficient_ready, 0);
    check("reset_write", out_clause_write, 0);
    check("reset_busy", out_busy, 0);
    check("reset_done", out_done, 0);
    check("reset_mask", out_reduce_enable, 0);
    check("reset_word", out_clause_coefficients, 0);
    check("reset_index", out_clause_index, 0);
    in_reset = 1'b0;

    gen_data(1'b1, 1'b0);
    run_load(1, 1'b0, 0, "single");
    check("single_literal_word", first_word, 40'hFB_04_03_02_01);
    check("single_mask_literal", out_reduce_enable, 8'b0000_0001);

    gen_data(1'b0, 1'b0);
    run_load(8, 1'b0, 0, "full8");
    check("full8_mask_literal", out_reduce_enable, 8'hFF);

    gen_data(1'b0, 1'b0);
    run_load(3, 1'b0, 0, "three_fast");
    run_load(3, 1'b1, 0, "three_stall");
    check("three_mask_literal", out_reduce_enable, 8'b0000_0111);

    run_load(0, 1'b0, 0, "zero");
    gen_data(1'b0, 1'b0);
    run_load(12, 1'b0, 0, "sat12");

    gen_data(1'b0, 1'b0);
    run_load(4, 1'b0, 2, "abort");
    gen_data(1'b0, 1'b0);
    run_load(4, 1'b0, 0, "after_abort");

    gen_data(1'b0, 1'b1);
    run_load(2, 1'b0, 0, "zero_clause");
`ifdef CLAUSE_LOADER_ZERO_CLAUSE_MASK_EN
    check("zero_clause_bit1", out_reduce_enable[1], 0);
`else
    check("zero_clause_bit1", out_reduce_enable[1], 1);
`endif

    for (int r = 0; r < 4; r++) begin
      gen_data(1'b0, 1'b0);
      run_load(int'($urandom_range(1, 15)), r[0], 0, "random");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
